// File: rtl/md_scheduler_if.sv
// Execute/Decode-side connection bundle for the multiply/divide sequencer.
interface md_scheduler_if;
  logic        E_md_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_md_use;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        pause_md;

  modport master (
    output E_md_start, E_md_op, E_rs, E_rt, D_md_use,
    input  busy, done, hi, lo, pause_md
  );

  modport slave (
    input  E_md_start, E_md_op, E_rs, E_rt, D_md_use,
    output busy, done, hi, lo, pause_md
  );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div sequencer with HI/LO holding registers.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | ready; accepts mult/div/mthi/mtlo from Execute
// MULT   | multiply in flight, r_cnt cycles left after this
// DIV    | divide in flight, r_cnt cycles left after this
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  md_scheduler_if.slave   md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, r_done;
  logic [31:0]      r_a, r_b, r_hi, r_lo;
  logic             r_signed;

  logic w_start_accept, w_load, w_mthi, w_mtlo, w_commit;

  // Datapath on the latched operands; only sampled at the commit edge.
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_start_accept = md.E_md_start & (r_state == S_IDLE) & (md.E_md_op <= 3'd5);

  assign w_a_ext = r_signed ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
  assign w_b_ext = r_signed ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_a_mag = (r_signed & r_a[31]) ? (-r_a) : r_a;
  assign w_b_mag = (r_signed & r_b[31]) ? (-r_b) : r_b;
  assign w_q_mag = (w_b_mag != 32'd0) ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r_mag = (w_b_mag != 32'd0) ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_quot  = (r_signed & (r_a[31] ^ r_b[31])) ? (-w_q_mag) : w_q_mag;
  assign w_rem   = (r_signed & r_a[31]) ? (-w_r_mag) : w_r_mag;

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_accept) begin
          case (md.E_md_op)
            3'd0, 3'd1: begin
              w_load      = 1'b1;
              w_cnt_nxt   = MULT_LOAD;
              w_state_nxt = S_MULT;
            end
            3'd2, 3'd3: begin
              w_load      = 1'b1;
              w_cnt_nxt   = DIV_LOAD;
              w_state_nxt = S_DIV;
            end
            3'd4:    w_mthi = 1'b1;
            default: w_mtlo = 1'b1;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, remaining-cycle counter, busy and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_commit;
    end
  end

  // Operand capture and HI/LO updates; a zero divisor leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_load) begin
        r_a      <= md.E_rs;
        r_b      <= md.E_rt;
        r_signed <= ~md.E_md_op[0];
      end
      if (w_mthi) r_hi <= md.E_rs;
      if (w_mtlo) r_lo <= md.E_rs;
      if (w_commit) begin
        if (r_state == S_MULT) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (r_b != 32'd0) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign md.busy     = r_busy;
  assign md.done     = r_done;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;
  assign md.pause_md = md.D_md_use & (r_busy | w_start_accept);

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed cases plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  md_scheduler_if u_if ();

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: HI/LO after the given op, from plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] nhi, output logic [31:0] nlo);
    longint q, r;
    logic [63:0] p;
    nhi = exp_hi;
    nlo = exp_lo;
    case (op)
      3'd0: begin
        q = longint'($signed(rs)) * longint'($signed(rt));
        p = q;
        nhi = p[63:32]; nlo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, rs} * {32'd0, rt};
        nhi = p[63:32]; nlo = p[31:0];
      end
      3'd2: if (rt != 0) begin
        q = longint'($signed(rs)) / longint'($signed(rt));
        r = longint'($signed(rs)) % longint'($signed(rt));
        nlo = q[31:0]; nhi = r[31:0];
      end
      3'd3: if (rt != 0) begin
        nlo = rs / rt; nhi = rs % rt;
      end
      3'd4: nhi = rs;
      3'd5: nlo = rs;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic d_use, input int inject_at);
    logic [31:0] nhi, nlo;
    int c;
    model(op, rs, rt, nhi, nlo);
    @(negedge clk);
    u_if.E_md_start = 1'b1; u_if.E_md_op = op; u_if.E_rs = rs; u_if.E_rt = rt;
    u_if.D_md_use = d_use;
    #1;
    check("pause_start", u_if.pause_md, d_use & (op <= 3'd5));
    @(posedge clk); #1;
    u_if.E_md_start = 1'b0;
    #1;
    if (op <= 3'd3) begin
      c = (op <= 3'd1) ? MC : DC;
      for (int k = 1; k <= c; k++) begin
        check("busy_high", u_if.busy, 1);
        check("done_low", u_if.done, 0);
        check("hold_hilo", {u_if.hi, u_if.lo}, {exp_hi, exp_lo});
        check("pause_busy", u_if.pause_md, d_use);
        if (k == inject_at) begin
          u_if.E_md_start = 1'b1; u_if.E_md_op = 3'd0; u_if.E_rs = 32'd2; u_if.E_rt = 32'd3;
          #1;
          check("pause_inject", u_if.pause_md, d_use);
        end
        @(posedge clk); #1;
        u_if.E_md_start = 1'b0;
        #1;
      end
      exp_hi = nhi; exp_lo = nlo;
      check("busy_end", u_if.busy, 0);
      check("done_pulse", u_if.done, 1);
      check("hi", u_if.hi, exp_hi);
      check("lo", u_if.lo, exp_lo);
      check("pause_after", u_if.pause_md, 0);
    end else begin
      exp_hi = nhi; exp_lo = nlo;
      check("busy_mt", u_if.busy, 0);
      check("done_mt", u_if.done, 0);
      check("hi_mt", u_if.hi, exp_hi);
      check("lo_mt", u_if.lo, exp_lo);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs, rt;
    reset = 1'b0;
    u_if.E_md_start = 1'b1; u_if.E_md_op = 3'd0; u_if.E_rs = 32'd9; u_if.E_rt = 32'd9;
    u_if.D_md_use = 1'b1;
    #12;
    check("rst_busy", u_if.busy, 0);
    check("rst_done", u_if.done, 0);
    check("rst_hi", u_if.hi, 0);
    check("rst_lo", u_if.lo, 0);
    check("rst_pause", u_if.pause_md, 1);
    u_if.E_md_start = 1'b0; u_if.D_md_use = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 0);
    @(posedge clk); #2;
    check("done_single", u_if.done, 0);
    do_op(3'd0, -32'sd3, 32'd7, 1'b0, 0);
    do_op(3'd2, -32'sd7, 32'd2, 1'b0, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(3'd4, 32'hAAAA_0000, 32'd0, 1'b0, 0);
    do_op(3'd5, 32'h0000_BBBB, 32'd0, 1'b0, 0);
    do_op(3'd3, 32'd123, 32'd0, 1'b0, 0);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0, 0);
    do_op(3'd5, 32'h5678, 32'd0, 1'b0, 0);
    do_op(3'd2, 32'd50, 32'd6, 1'b1, 0);
    do_op(3'd3, 32'd100, 32'd7, 1'b1, 3);
    do_op(3'd6, 32'hDEAD, 32'd1, 1'b1, 0);

    // Reset asserted in the third busy cycle of a mult.
    @(negedge clk);
    u_if.E_md_start = 1'b1; u_if.E_md_op = 3'd0; u_if.E_rs = 32'd4; u_if.E_rt = 32'd5;
    u_if.D_md_use = 1'b0;
    @(posedge clk); #1;
    u_if.E_md_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("pre_rst_busy", u_if.busy, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", u_if.busy, 0);
    check("abort_done", u_if.done, 0);
    check("abort_hi", u_if.hi, 0);
    check("abort_lo", u_if.lo, 0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    do_op(3'd1, 32'd5, 32'd5, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 20));
        2: rt = -32'($urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rs = -32'($urandom_range(0, 1000));
      do_op(op, rs, rt, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    @(posedge clk); #2;
    check("final_done", u_if.done, 0);
    check("final_busy", u_if.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multi-cycle multiply/divide sequencer with HI/LO holding registers for the five-stage pipeline. It sits beside the Execute stage: it accepts an MD operation from E and runs it over a fixed number of cycles. It holds the result in HI/LO and raises the pause request that freezes Fetch/Decode and bubbles ID2EX while an MD-class instruction in D would conflict.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- E_md_start  in  1  valid MD operation in Execute this cycle (already gated by E_lat)
- E_md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved (no-op)
- E_rs  in  32  forwarded rs operand
- E_rt  in  32  forwarded rt operand
- D_md_use  in  1  instruction in Decode is MD-class (mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
- busy  out  1  registered; operation in flight
- done  out  1  registered one-cycle pulse on result commit
- hi  out  32  HI register
- lo  out  32  LO register
- pause_md  out  1  combinational: D_md_use & (busy | start_accept)

## Operation
- States: IDLE, MULT, DIV. A down-counter `cnt` tracks the remaining cycles and is sized for max(MULT_CYCLES, DIV_CYCLES).
- start_accept = E_md_start & (state == IDLE) & op ≤ 5.
- IDLE with start_accept:
  - op 0/1: latch operands, cnt ← MULT_CYCLES−1, go to MULT.
  - op 2/3: latch operands, cnt ← DIV_CYCLES−1, go to DIV.
  - op 4: hi ← E_rs at this edge; stay in IDLE; no busy, no done.
  - op 5: lo ← E_rs likewise.
- MULT/DIV: if cnt ≠ 0, cnt ← cnt−1. If cnt == 0, commit {hi,lo}, pulse done, return to IDLE.
- E_md_start while not IDLE is ignored; the pipeline guarantees this via pause_md. The operands and the result of the in-flight operation are unaffected.
- Reserved op (6–7) is ignored in every state.
- Arithmetic, computed on the latched operands:
  - mult: signed 32×32 → 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32×32 → 64, same split.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - divu: unsigned quotient/remainder.
  - Divisor zero (div/divu): hi/lo retain their prior values. The operation still takes DIV_CYCLES, and done still pulses.
- mfhi/mflo read hi/lo directly. They are correct whenever not paused, because pause_md holds them in D until the result commits.

## Timing
- Reset (reset = 0, asynchronous): state IDLE, cnt 0, hi 0, lo 0, busy 0, done 0. pause_md follows D_md_use & start_accept combinationally.
- Reset mid-operation aborts it: hi/lo go to 0, no done pulse, and busy drops immediately.
- Capture edge T0 (start_accept high, op mult/div):
  - busy is 1 for exactly C cycles after T0, where C = MULT_CYCLES or DIV_CYCLES.
  - hi/lo take the result and done = 1 on edge T0+C.
  - busy = 0 from T0+C onward.
- Back-to-back: a new start_accept is possible in the cycle following T0+C.
- mthi/mtlo latency: hi/lo are updated at the capture edge; visible the next cycle.
- pause_md:
  - Asserted in the start cycle and in every busy cycle whenever D_md_use = 1.
  - Deasserts in the cycle after the commit edge.

## Test plan
- After reset release: multu E_rs=0xFFFFFFFF, E_rt=0x2 → busy high 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE, single done pulse.
- mult −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB after 5 cycles. div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 123 / 0 with prior hi=0xAAAA0000, lo=0x0000BBBB → busy 10 cycles, done pulses, hi/lo unchanged. mthi 0x1234 then mtlo 0x5678 in consecutive cycles → hi=0x1234, lo=0x5678, busy never asserted.
- D_md_use held 1 while div starts → pause_md high in the start cycle and all 10 busy cycles, low in the cycle after commit. D_md_use=0 → pause_md always 0.
- E_md_start (mult 2×3) asserted during a busy divu 100/7 → ignored; result hi=2, lo=14, completes on schedule.
- reset driven 0 in the 3rd busy cycle of mult → busy, done, hi, lo all 0 immediately. After release, a new multu 5×5 gives lo=25 in 5 cycles.
